// File: rtl/btn_sw_debounce_pkg.sv
// Shared types and default timing constants for the button/switch debounce front end.
package debounce_pkg;

  typedef enum logic [1:0] {ST_LOW, ST_ARM_HI, ST_HIGH, ST_ARM_LO} deb_state_t;

  localparam int DEB_N_CH         = 8;
  localparam int DEB_TICK_DIV     = 100000;
  localparam int DEB_STABLE_TICKS = 10;
  localparam int DEB_LONG_TICKS   = 1000;
  localparam int DEB_SYNC_STAGES  = 2;

endpackage

// File: rtl/btn_sw_debounce_if.sv
// Pad-side inputs and conditioned per-channel outputs of the debounce block.
interface btn_sw_debounce_if
  import debounce_pkg::*;
#(
  parameter int N_CH = DEB_N_CH
) ();

  logic [N_CH-1:0] din;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] long_press;

  modport master (
    output din,
    input  level,
    input  rise,
    input  fall,
    input  long_press
  );

  modport slave (
    input  din,
    output level,
    output rise,
    output fall,
    output long_press
  );

endinterface

// File: rtl/btn_sw_debounce_ch.sv
// One debounce channel: pad synchroniser, stability FSM, debounce and hold counters.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEB_STABLE_TICKS,
  parameter int LONG_TICKS   = DEB_LONG_TICKS,
  parameter int SYNC_STAGES  = DEB_SYNC_STAGES
) (
  input  logic clk_100,
  input  logic reset_n,
  input  logic tick,
  input  logic din_raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int DEB_W  = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam int HOLD_W = $clog2(LONG_TICKS + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(STABLE_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  deb_state_t             state_q, state_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic                   long_done_q, long_done_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   long_q, long_d;
  logic                   s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], din_raw};
  assign s      = sync_q[SYNC_STAGES-1];

  // A change of s wins over a coincident tick: the tick is simply not counted.
  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    long_d      = 1'b0;
    unique case (state_q)
      ST_LOW: begin
        level_d = 1'b0;
        if (s) begin
          state_d   = ST_ARM_HI;
          deb_cnt_d = '0;
        end
      end
      ST_ARM_HI: begin
        if (!s) begin
          state_d = ST_LOW;
        end else if (tick) begin
          if (deb_cnt_q == DEB_LAST) begin
            state_d     = ST_HIGH;
            level_d     = 1'b1;
            rise_d      = 1'b1;
            hold_cnt_d  = '0;
            long_done_d = 1'b0;
          end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
          end
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_d   = ST_ARM_LO;
          deb_cnt_d = '0;
        end else if (tick) begin
          if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          if (hold_cnt_q == HOLD_LAST && !long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end
        end
      end
      ST_ARM_LO: begin
        if (s) begin
          state_d = ST_HIGH;
        end else if (tick) begin
          if (deb_cnt_q == DEB_LAST) begin
            state_d = ST_LOW;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
          end
        end
      end
      default: state_d = ST_LOW;
    endcase
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      state_q     <= ST_LOW;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      long_q      <= long_d;
    end
  end

  assign level      = level_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign long_press = long_q;

endmodule

// File: rtl/btn_sw_debounce.sv
// Debounce front end: shared tick prescaler feeding N_CH independent channels.
module btn_sw_debounce
  import debounce_pkg::*;
#(
  parameter int N_CH         = DEB_N_CH,
  parameter int TICK_DIV     = DEB_TICK_DIV,
  parameter int STABLE_TICKS = DEB_STABLE_TICKS,
  parameter int LONG_TICKS   = DEB_LONG_TICKS,
  parameter int SYNC_STAGES  = DEB_SYNC_STAGES
) (
  input  logic                     clk_100,
  input  logic                     reset_n,
  btn_sw_debounce_if.slave         bus
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick;
  logic [N_CH-1:0]    level_w, rise_w, fall_w, long_w;

  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) presc_q <= '0;
    else          presc_q <= presc_d;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .STABLE_TICKS (STABLE_TICKS),
      .LONG_TICKS   (LONG_TICKS),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_ch (
      .clk_100    (clk_100),
      .reset_n    (reset_n),
      .tick       (tick),
      .din_raw    (bus.din[i]),
      .level      (level_w[i]),
      .rise       (rise_w[i]),
      .fall       (fall_w[i]),
      .long_press (long_w[i])
    );
  end

  assign bus.level      = level_w;
  assign bus.rise       = rise_w;
  assign bus.fall       = fall_w;
  assign bus.long_press = long_w;

endmodule

// File: tb/tb_btn_sw_debounce.sv
// Directed bench for btn_sw_debounce with a short tick (4), 3 stable ticks, 8 long ticks.
module tb_btn_sw_debounce;

  localparam int N = 8;

  logic clk_100 = 1'b0;
  logic reset_n = 1'b0;

  btn_sw_debounce_if #(.N_CH(N)) bus ();

  btn_sw_debounce #(
    .N_CH         (N),
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .LONG_TICKS   (8),
    .SYNC_STAGES  (2)
  ) dut (
    .clk_100 (clk_100),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_100 = ~clk_100;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int overlap = 0;
  int rise_cnt [N];
  int fall_cnt [N];
  int long_cnt [N];
  int rise_cyc [N];
  int fall_cyc [N];
  int long_cyc [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) begin
      rise_cnt[i] = 0; fall_cnt[i] = 0; long_cnt[i] = 0;
      rise_cyc[i] = -1; fall_cyc[i] = -1; long_cyc[i] = -1;
    end
  endtask

  // Advance n cycles, sampling 1 ns after each edge and logging every pulse.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_100);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (bus.rise[i])       begin rise_cnt[i]++; rise_cyc[i] = cyc; end
        if (bus.fall[i])       begin fall_cnt[i]++; fall_cyc[i] = cyc; end
        if (bus.long_press[i]) begin long_cnt[i]++; long_cyc[i] = cyc; end
        if ((bus.rise[i] && bus.fall[i]) || (bus.rise[i] && bus.long_press[i]) ||
            (bus.fall[i] && bus.long_press[i]))
          overlap++;
      end
    end
  endtask

  function automatic logic in_win(input int lat);
    return (lat >= 11 && lat <= 15);
  endfunction

  int t0;
  int tmp;

  initial begin
    bus.din = 8'hFF;
    clr();
    // 1: all inputs high through reset
    #1;
    chk("rst_level", bus.level, 8'h00);
    chk("rst_pulses", {bus.rise, bus.fall, bus.long_press}, 24'h0);
    run(3);
    chk("rst_hold_level", bus.level, 8'h00);
    reset_n = 1'b1;
    t0 = cyc;
    run(20);
    tmp = 0;
    for (int i = 0; i < N; i++) if (rise_cnt[i] == 1) tmp++;
    chk("t1_rise_once_all", tmp, 8);
    chk("t1_rise_lat", in_win(rise_cyc[0] - t0), 1'b1);
    chk("t1_rise_same_cycle", rise_cyc[7] - rise_cyc[0], 0);
    chk("t1_level", bus.level, 8'hFF);

    bus.din = 8'h00;
    clr();
    run(20);
    tmp = 0;
    for (int i = 0; i < N; i++) if (fall_cnt[i] == 1) tmp++;
    chk("t1_fall_once_all", tmp, 8);
    chk("t1_level_low", bus.level, 8'h00);

    // 3a: 6-cycle high glitch on ch0
    clr();
    bus.din[0] = 1'b1;
    run(6);
    bus.din[0] = 1'b0;
    run(20);
    chk("t3_glitch_rise", rise_cnt[0], 0);
    chk("t3_glitch_level", bus.level[0], 1'b0);

    // 2: clean rise on ch0
    clr();
    bus.din[0] = 1'b1;
    t0 = cyc;
    run(20);
    chk("t2_rise_cnt", rise_cnt[0], 1);
    chk("t2_rise_lat", in_win(rise_cyc[0] - t0), 1'b1);
    chk("t2_level", bus.level, 8'h01);
    tmp = 0;
    for (int i = 1; i < N; i++) tmp += rise_cnt[i];
    chk("t2_others_quiet", tmp, 0);

    // 3b: 6-cycle low dip while ch0 is high
    clr();
    bus.din[0] = 1'b0;
    run(6);
    bus.din[0] = 1'b1;
    run(20);
    chk("t3_dip_fall", fall_cnt[0], 0);
    chk("t3_dip_level", bus.level[0], 1'b1);

    // 4: ch1 bouncing every 3 cycles, then held
    clr();
    for (int k = 0; k < 10; k++) begin
      bus.din[1] = ~bus.din[1];
      run(3);
    end
    chk("t4_no_early_rise", rise_cnt[1], 0);
    bus.din[1] = 1'b1;
    t0 = cyc;
    run(20);
    chk("t4_rise_cnt", rise_cnt[1], 1);
    chk("t4_rise_lat", in_win(rise_cyc[1] - t0), 1'b1);
    chk("t4_level", bus.level[1], 1'b1);

    // 5: long press on ch2
    clr();
    bus.din[2] = 1'b1;
    run(60);
    chk("t5_rise_cnt", rise_cnt[2], 1);
    chk("t5_long_cnt", long_cnt[2], 1);
    chk("t5_long_at_8th_tick", long_cyc[2] - rise_cyc[2], 32);
    run(40);
    chk("t5_long_not_repeated", long_cnt[2], 1);
    bus.din[2] = 1'b0;
    run(20);
    chk("t5_fall_cnt", fall_cnt[2], 1);
    chk("t5_level", bus.level[2], 1'b0);

    // 6: asynchronous reset while ch3 is arming
    clr();
    bus.din[3] = 1'b1;
    run(6);
    chk("t6_armed_no_rise", rise_cnt[3], 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_level", bus.level, 8'h00);
    chk("t6_async_pulses", {bus.rise, bus.fall, bus.long_press}, 24'h0);
    run(2);
    clr();
    reset_n = 1'b1;
    t0 = cyc;
    run(20);
    chk("t6_rise_cnt", rise_cnt[3], 1);
    chk("t6_rise_lat", in_win(rise_cyc[3] - t0), 1'b1);
    chk("t6_level", bus.level[3], 1'b1);

    chk("no_pulse_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
